// File: rtl/a_neuron_feeder.sv
// a_neuron_feeder: sequences one a_neuron evaluation (weight strobe, zero pulse, BEATS x LANES stream, capture).
// Optional macro A_NEURON_FEEDER_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
module a_neuron_feeder #(
    parameter int LANES  = 5,
    parameter int BEATS  = 80,
    parameter int DW     = 8,
    parameter int QW     = 9,
    parameter int SETTLE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                load_w,
    output logic                busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANES*DW-1:0] in_d,
    output logic                nrn_wr_weights,
    output logic                nrn_z,
    output logic                nrn_en,
    output logic [LANES*DW-1:0] nrn_d,
    input  logic [QW-1:0]       nrn_q,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [QW-1:0]       out_q
`ifdef A_NEURON_FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]         stall_cnt
`endif
);

    localparam int CW = $clog2(BEATS + 1);
    localparam int SW = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WRW, S_ZERO, S_STREAM, S_SETTLE, S_RESULT
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       beat_cnt_q, beat_cnt_d;
    logic [SW-1:0]       settle_cnt_q, settle_cnt_d;
    logic                busy_q, busy_d;
    logic                in_ready_q, in_ready_d;
    logic                wr_q, wr_d;
    logic                z_q, z_d;
    logic                en_q, en_d;
    logic [LANES*DW-1:0] nrn_d_q, nrn_d_d;
    logic                out_valid_q, out_valid_d;
    logic [QW-1:0]       out_q_q, out_q_d;
`ifdef A_NEURON_FEEDER_STALL_CNT_EN
    logic [15:0]         stall_cnt_q, stall_cnt_d;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        settle_cnt_d = settle_cnt_q;
        nrn_d_d      = nrn_d_q;
        en_d         = 1'b0;
        out_valid_d  = out_valid_q;
        out_q_d      = out_q_q;
`ifdef A_NEURON_FEEDER_STALL_CNT_EN
        stall_cnt_d  = stall_cnt_q;
`endif
        case (state_q)
            S_IDLE: if (start) state_d = load_w ? S_WRW : S_ZERO;
            S_WRW:  state_d = S_ZERO;
            S_ZERO: begin
                beat_cnt_d = '0;
`ifdef A_NEURON_FEEDER_STALL_CNT_EN
                stall_cnt_d = '0;
`endif
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (in_valid && in_ready_q) begin
                    nrn_d_d    = in_d;
                    en_d       = 1'b1;
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (beat_cnt_q == CW'(BEATS - 1)) begin
                        settle_cnt_d = '0;
                        state_d      = S_SETTLE;
                    end
                end
`ifdef A_NEURON_FEEDER_STALL_CNT_EN
                if (!in_valid && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
`endif
            end
            // The first SETTLE cycle still carries the final en beat, so the
            // SETTLE-cycle wait starts after it.
            S_SETTLE: begin
                if (settle_cnt_q == SW'(SETTLE)) begin
                    out_q_d     = nrn_q;
                    out_valid_d = 1'b1;
                    state_d     = S_RESULT;
                end else begin
                    settle_cnt_d = settle_cnt_q + SW'(1);
                end
            end
            S_RESULT: if (out_ready) begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes are registered from the next state so they align with it.
        busy_d     = (state_d != S_IDLE);
        in_ready_d = (state_d == S_STREAM);
        wr_d       = (state_d == S_WRW);
        z_d        = (state_d == S_ZERO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            beat_cnt_q   <= '0;
            settle_cnt_q <= '0;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            wr_q         <= 1'b0;
            z_q          <= 1'b0;
            en_q         <= 1'b0;
            nrn_d_q      <= '0;
            out_valid_q  <= 1'b0;
            out_q_q      <= '0;
`ifdef A_NEURON_FEEDER_STALL_CNT_EN
            stall_cnt_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            busy_q       <= busy_d;
            in_ready_q   <= in_ready_d;
            wr_q         <= wr_d;
            z_q          <= z_d;
            en_q         <= en_d;
            nrn_d_q      <= nrn_d_d;
            out_valid_q  <= out_valid_d;
            out_q_q      <= out_q_d;
`ifdef A_NEURON_FEEDER_STALL_CNT_EN
            stall_cnt_q  <= stall_cnt_d;
`endif
        end
    end

    assign busy           = busy_q;
    assign in_ready       = in_ready_q;
    assign nrn_wr_weights = wr_q;
    assign nrn_z          = z_q;
    assign nrn_en         = en_q;
    assign nrn_d          = nrn_d_q;
    assign out_valid      = out_valid_q;
    assign out_q          = out_q_q;
`ifdef A_NEURON_FEEDER_STALL_CNT_EN
    assign stall_cnt      = stall_cnt_q;
`endif

endmodule

// File: tb/tb_a_neuron_feeder.sv
// Self-checking bench for a_neuron_feeder with a behavioural neuron and a direct dot-product reference.
module tb_a_neuron_feeder;

    localparam int LANES = 5, BEATS = 80, DW = 8, QW = 9, SETTLE = 1;
    localparam int NIN = LANES * BEATS, NSRC = 200;

    logic                clk, rst_n, start, load_w, busy;
    logic                in_valid, in_ready;
    logic [LANES*DW-1:0] in_d, nrn_d;
    logic                nrn_wr_weights, nrn_z, nrn_en;
    logic [QW-1:0]       nrn_q, out_q;
    logic                out_valid, out_ready;
`ifdef A_NEURON_FEEDER_STALL_CNT_EN
    logic [15:0]         stall_cnt;
`endif

    a_neuron_feeder #(.LANES(LANES), .BEATS(BEATS), .DW(DW), .QW(QW), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .load_w(load_w), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_d(in_d),
        .nrn_wr_weights(nrn_wr_weights), .nrn_z(nrn_z), .nrn_en(nrn_en), .nrn_d(nrn_d),
        .nrn_q(nrn_q), .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q)
`ifdef A_NEURON_FEEDER_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    int checks = 0, errors = 0;

    int w_stage[NIN], w_nrn[NIN], w_ref[NIN];
    int bias_stage, bias_nrn, bias_ref;
    int acc, nidx;
    logic [LANES*DW-1:0] src[NSRC];
    int src_idx, src_n;
    int n_wr, n_z, n_en, n_busy, n_low, n_acc, n_valid;
    bit hold_bad;
    logic [QW-1:0] got_q, exp;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Sign-magnitude tanh stand-in: magnitude scaled down and saturated to 8 bits.
    function automatic logic [QW-1:0] q_of(input int a);
        int m;
        m = (a < 0) ? -a : a;
        m = m >>> 7;
        if (m > 255) m = 255;
        return {(a < 0) ? 1'b1 : 1'b0, 8'(m)};
    endfunction

    function automatic int lane_dot(input logic [LANES*DW-1:0] d, input int base);
        int s = 0;
        for (int k = 0; k < LANES; k++)
            if (base + k < NIN) s += int'(d[k*DW +: DW]) * w_nrn[base + k];
        return s;
    endfunction

    function automatic logic [QW-1:0] exp_q(input int base);
        int a;
        logic [DW-1:0] b;
        logic [LANES*DW-1:0] beat;
        a = bias_ref;
        for (int i = 0; i < NIN; i++) begin
            beat = src[base + i / LANES];
            b = beat[(i % LANES)*DW +: DW];
            a += int'(b) * w_ref[i];
        end
        return q_of(a);
    endfunction

    // Behavioural neuron: weight latch on wr_weights, bias preload on z, accumulate on en.
    always @(posedge clk) begin
        if (nrn_wr_weights) begin
            for (int i = 0; i < NIN; i++) w_nrn[i] <= w_stage[i];
            bias_nrn <= bias_stage;
        end
        if (nrn_z) begin
            acc  <= bias_nrn;
            nidx <= 0;
        end else if (nrn_en) begin
            acc  <= acc + lane_dot(nrn_d, nidx);
            nidx <= nidx + LANES;
        end
    end
    assign nrn_q = q_of(acc);

    task automatic init_weights();
        for (int i = 0; i < NIN; i++) w_stage[i] = int'($urandom_range(15)) - 8;
        bias_stage = int'($urandom_range(4000)) - 2000;
    endtask

    task automatic latch_ref();
        for (int i = 0; i < NIN; i++) w_ref[i] = w_stage[i];
        bias_ref = bias_stage;
    endtask

    // Runs one evaluation starting at a negedge; returns at a negedge.
    task automatic run_eval(input bit lw, input int stall_pct, input int ready_delay, input int abort_at);
        int cyc;
        bit done;
        n_wr = 0; n_z = 0; n_en = 0; n_busy = 0; n_low = 0; n_acc = 0; n_valid = 0;
        hold_bad = 0; done = 0; cyc = 0; got_q = '0;
        start = 1'b1; load_w = lw;
        while (!done) begin
            if (src_idx < src_n) begin
                in_d = src[src_idx];
                in_valid = ($urandom_range(99) >= stall_pct);
            end else begin
                in_d = '0;
                in_valid = 1'b0;
            end
            if (cyc > 0) start = 1'b0;
            out_ready = 1'b0;
            if (nrn_wr_weights) n_wr++;
            if (nrn_z) n_z++;
            if (nrn_en) n_en++;
            if (busy) n_busy++;
            if (in_ready && !in_valid) n_low++;
            if (in_ready && in_valid) begin
                src_idx++;
                n_acc++;
            end
            if (out_valid) begin
                if (n_valid == 0) got_q = out_q;
                else if (out_q !== got_q) hold_bad = 1;
                n_valid++;
                if (n_valid > ready_delay) begin
                    out_ready = 1'b1;
                    done = 1;
                end else if (n_valid % 2 == 1) begin
                    start = 1'b1;
                    load_w = 1'b1;
                end
            end
            if (abort_at > 0 && n_acc == abort_at) return;
            if (cyc >= 2000) begin
                checks++; errors++;
                $display("FAIL eval_timeout: got no completed result after %0d cycles, required one", cyc);
                return;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        if (src_idx < src_n) begin
            in_d = src[src_idx];
            in_valid = 1'b1;
        end else begin
            in_d = '0;
            in_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
        checks++; if (nrn_wr_weights !== 1'b0) begin errors++; $display("FAIL rst_wr: got %b required 0", nrn_wr_weights); end
        checks++; if (nrn_z !== 1'b0) begin errors++; $display("FAIL rst_z: got %b required 0", nrn_z); end
        checks++; if (nrn_en !== 1'b0) begin errors++; $display("FAIL rst_en: got %b required 0", nrn_en); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        checks++; if (nrn_d !== '0) begin errors++; $display("FAIL rst_nrn_d: got %h required 0", nrn_d); end
        checks++; if (out_q !== '0) begin errors++; $display("FAIL rst_out_q: got %h required 0", out_q); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_eval();
        init_weights();
        latch_ref();
        src_idx = 0; src_n = BEATS;
        run_eval(1'b1, 0, 0, 0);
        exp = exp_q(0);
        checks++; if (n_wr !== 1) begin errors++; $display("FAIL full_wr_cycles: got %0d required 1", n_wr); end
        checks++; if (n_z !== 1) begin errors++; $display("FAIL full_z_cycles: got %0d required 1", n_z); end
        checks++; if (n_en !== BEATS) begin errors++; $display("FAIL full_en_cycles: got %0d required %0d", n_en, BEATS); end
        checks++; if (n_acc !== BEATS) begin errors++; $display("FAIL full_accepted: got %0d required %0d", n_acc, BEATS); end
        checks++; if (n_busy !== 84 + SETTLE) begin errors++; $display("FAIL full_busy_cycles: got %0d required %0d", n_busy, 84 + SETTLE); end
        checks++; if (got_q !== exp) begin errors++; $display("FAIL full_out_q: got %h required %h", got_q, exp); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_idle_after: got busy=%b required 0", busy); end
    endtask

    task automatic test_stall();
        src_idx = 0; src_n = BEATS;
        run_eval(1'b1, 50, 0, 0);
        exp = exp_q(0);
        checks++; if (n_en !== BEATS) begin errors++; $display("FAIL stall_en_cycles: got %0d required %0d", n_en, BEATS); end
        checks++; if (got_q !== exp) begin errors++; $display("FAIL stall_out_q: got %h required %h", got_q, exp); end
`ifdef A_NEURON_FEEDER_STALL_CNT_EN
        checks++; if (stall_cnt !== 16'(n_low)) begin errors++; $display("FAIL stall_cnt: got %0d required %0d", stall_cnt, n_low); end
`endif
    endtask

    task automatic test_reuse_weights();
        init_weights();
        src_idx = BEATS; src_n = 2 * BEATS;
        run_eval(1'b0, 0, 0, 0);
        exp = exp_q(BEATS);
        checks++; if (n_wr !== 0) begin errors++; $display("FAIL reuse_wr_cycles: got %0d required 0", n_wr); end
        checks++; if (n_z !== 1) begin errors++; $display("FAIL reuse_z_cycles: got %0d required 1", n_z); end
        checks++; if (got_q !== exp) begin errors++; $display("FAIL reuse_out_q: got %h required %h", got_q, exp); end
    endtask

    task automatic test_result_hold();
        src_idx = 0; src_n = BEATS;
        run_eval(1'b0, 0, 10, 0);
        exp = exp_q(0);
        checks++; if (hold_bad !== 1'b0) begin errors++; $display("FAIL hold_out_q_stable: got changed=%b required 0", hold_bad); end
        checks++; if (n_valid !== 11) begin errors++; $display("FAIL hold_valid_cycles: got %0d required 11", n_valid); end
        checks++; if (got_q !== exp) begin errors++; $display("FAIL hold_out_q: got %h required %h", got_q, exp); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_idle_after: got busy=%b required 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_valid_drop: got %b required 0", out_valid); end
    endtask

    task automatic test_overflow();
        src_idx = 0; src_n = BEATS + 1;
        run_eval(1'b0, 0, 0, 0);
        exp = exp_q(0);
        checks++; if (n_acc !== BEATS) begin errors++; $display("FAIL ovf_accepted: got %0d required %0d", n_acc, BEATS); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ovf_in_ready: got %b required 0", in_ready); end
        checks++; if (got_q !== exp) begin errors++; $display("FAIL ovf_out_q: got %h required %h", got_q, exp); end
        src_n = 2 * BEATS;
        run_eval(1'b0, 0, 0, 0);
        exp = exp_q(BEATS);
        checks++; if (n_acc !== BEATS) begin errors++; $display("FAIL ovf_next_accepted: got %0d required %0d", n_acc, BEATS); end
        checks++; if (got_q !== exp) begin errors++; $display("FAIL ovf_next_out_q: got %h required %h", got_q, exp); end
    endtask

    task automatic test_reset_mid();
        init_weights();
        latch_ref();
        src_idx = 0; src_n = BEATS;
        run_eval(1'b1, 0, 0, 40);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b required 0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready: got %b required 0", in_ready); end
        checks++; if (nrn_en !== 1'b0) begin errors++; $display("FAIL mid_en: got %b required 0", nrn_en); end
        checks++; if (nrn_d !== '0) begin errors++; $display("FAIL mid_nrn_d: got %h required 0", nrn_d); end
        checks++; if (out_q !== '0) begin errors++; $display("FAIL mid_out_q: got %h required 0", out_q); end
        start = 1'b0; in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        src_idx = BEATS; src_n = 2 * BEATS;
        run_eval(1'b1, 0, 0, 0);
        exp = exp_q(BEATS);
        checks++; if (n_en !== BEATS) begin errors++; $display("FAIL mid_new_en_cycles: got %0d required %0d", n_en, BEATS); end
        checks++; if (got_q !== exp) begin errors++; $display("FAIL mid_new_out_q: got %h required %h", got_q, exp); end
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; load_w = 1'b0;
        in_valid = 1'b0; in_d = '0; out_ready = 1'b0;
        for (int i = 0; i < NSRC; i++) src[i] = {8'($urandom()), 32'($urandom())};
        #2 rst_n = 1'b0;
        test_reset();
        test_full_eval();
        test_stall();
        test_reuse_weights();
        test_result_hold();
        test_overflow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
